// File: rtl/icap_stream_writer.sv
// icap_stream_writer: buffers a 16-bit write stream in a FIFO and feeds the ICAP port with CE/WRITE sequencing
module icap_stream_writer #(
  parameter int FIFO_AW = 4,
  parameter bit BIT_SWAP = 1'b1
) (
  input  logic        bus_clk,
  input  logic        rst,
  input  logic        user_w_icap_in_wren,
  input  logic [15:0] user_w_icap_in_data,
  output logic        user_w_icap_in_full,
  input  logic        user_w_icap_in_open,
  output logic        icap_ce_n,
  output logic        icap_write_n,
  output logic [15:0] icap_i,
  input  logic        icap_busy,
  output logic [31:0] words_written,
  output logic        overflow,
  output logic        active
);
  localparam int DEPTH = 1 << FIFO_AW;
  typedef enum logic [2:0] {IDLE, ARM, STREAM, DRAIN, DISARM} state_t;
  state_t state, state_nx;
  logic [15:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0] count;
  logic [15:0] head, swapped;
  logic open_q, open_rise, empty, push, pop, drop, accept, ce_nx, write_nx;
  assign user_w_icap_in_full = count[FIFO_AW];
  assign empty = count == '0;
  assign push = user_w_icap_in_wren && !user_w_icap_in_full;
  assign drop = user_w_icap_in_wren && user_w_icap_in_full;
  assign open_rise = user_w_icap_in_open && !open_q;
  assign head = mem[rd_ptr];
  for (genvar i = 0; i < 16; i++) begin : g_swap
    assign swapped[i] = BIT_SWAP ? head[(i / 8) * 8 + 7 - i % 8] : head[i];
  end
  // FIFO storage, written only on accepted pushes
  always_ff @(posedge bus_clk) begin
    if (push) mem[wr_ptr] <= user_w_icap_in_data;
  end
  // next state and CE/WRITE sequencing; STREAM and DRAIN share the data rules
  always_comb begin
    state_nx = state;
    ce_nx = icap_ce_n;
    write_nx = icap_write_n;
    pop = 1'b0;
    accept = (state == STREAM || state == DRAIN) && !icap_ce_n && !icap_busy;
    case (state)
      IDLE: state_nx = empty ? IDLE : ARM;
      ARM: begin
        write_nx = 1'b0;
        state_nx = STREAM;
      end
      STREAM, DRAIN: begin
        pop = !empty && (icap_ce_n || accept);
        ce_nx = !(pop || (!icap_ce_n && !accept));
        state_nx = user_w_icap_in_open ? STREAM : (empty && (icap_ce_n || accept)) ? DISARM : DRAIN;
      end
      DISARM: begin
        write_nx = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  // registered outputs, FIFO pointers and session statistics
  always_ff @(posedge bus_clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      icap_ce_n <= 1'b1;
      icap_write_n <= 1'b1;
      icap_i <= '0;
      active <= 1'b0;
      open_q <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      words_written <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      icap_ce_n <= ce_nx;
      icap_write_n <= write_nx;
      if (pop) icap_i <= swapped;
      active <= state_nx != IDLE;
      open_q <= user_w_icap_in_open;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);
      if (open_rise) words_written <= {31'b0, accept};
      else if (accept && ~&words_written) words_written <= words_written + 32'd1;
      overflow <= open_rise ? drop : overflow || drop;
    end
  end
endmodule

// File: tb/tb_icap_stream_writer.sv
// tb_icap_stream_writer: directed self-checking bench for icap_stream_writer
module tb_icap_stream_writer;
  logic bus_clk = 1'b0;
  logic rst = 1'b1;
  logic wren = 1'b0, open = 1'b0, busy = 1'b0;
  logic [15:0] data = '0;
  logic full, ce_n, write_n, overflow, active;
  logic [15:0] icap_i;
  logic [31:0] words;
  logic wren0 = 1'b0, open0 = 1'b0, busy0 = 1'b0;
  logic [15:0] data0 = '0;
  logic full0, ce_n0, write_n0, overflow0, active0;
  logic [15:0] icap_i0;
  logic [31:0] words0;
  int total = 0;
  int bad = 0;

  icap_stream_writer dut (
    .bus_clk(bus_clk), .rst(rst),
    .user_w_icap_in_wren(wren), .user_w_icap_in_data(data), .user_w_icap_in_full(full),
    .user_w_icap_in_open(open), .icap_ce_n(ce_n), .icap_write_n(write_n), .icap_i(icap_i),
    .icap_busy(busy), .words_written(words), .overflow(overflow), .active(active)
  );

  icap_stream_writer #(.BIT_SWAP(1'b0)) dut0 (
    .bus_clk(bus_clk), .rst(rst),
    .user_w_icap_in_wren(wren0), .user_w_icap_in_data(data0), .user_w_icap_in_full(full0),
    .user_w_icap_in_open(open0), .icap_ce_n(ce_n0), .icap_write_n(write_n0), .icap_i(icap_i0),
    .icap_busy(busy0), .words_written(words0), .overflow(overflow0), .active(active0)
  );

  always #5 bus_clk = ~bus_clk;

  task automatic tick;
    @(negedge bus_clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    total++;
    if ({ce_n, write_n, icap_i, words, overflow, active, full} !== {1'b1, 1'b1, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_values got ce_n=%b wn=%b i=%h w=%0d ov=%b act=%b full=%b", ce_n, write_n, icap_i, words, overflow, active, full);
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_basic;
    open = 1'b1;
    tick;
    wren = 1'b1;
    data = 16'h0102;
    tick;
    data = 16'hAA99;
    tick;
    wren = 1'b0;
    total++;
    if ({active, write_n, ce_n} !== 3'b111) begin bad++; $display("FAIL basic_arm got act/wn/ce=%b exp 111", {active, write_n, ce_n}); end
    tick;
    total++;
    if ({write_n, ce_n} !== 2'b01) begin bad++; $display("FAIL basic_write_first got wn/ce=%b exp 01", {write_n, ce_n}); end
    tick;
    total++;
    if (ce_n !== 1'b0 || icap_i !== 16'h8040) begin bad++; $display("FAIL basic_word1 got ce_n=%b i=%h exp 0 8040", ce_n, icap_i); end
    tick;
    total++;
    if (ce_n !== 1'b0 || icap_i !== 16'h5599 || words !== 32'd1) begin bad++; $display("FAIL basic_word2 got ce_n=%b i=%h w=%0d exp 0 5599 1", ce_n, icap_i, words); end
    tick;
    total++;
    if (ce_n !== 1'b1 || write_n !== 1'b0 || words !== 32'd2) begin bad++; $display("FAIL basic_done got ce_n=%b wn=%b w=%0d exp 1 0 2", ce_n, write_n, words); end
    open = 1'b0;
    tick;
    total++;
    if (write_n !== 1'b0 || active !== 1'b1) begin bad++; $display("FAIL basic_disarm got wn=%b act=%b exp 0 1", write_n, active); end
    tick;
    total++;
    if (write_n !== 1'b1 || active !== 1'b0) begin bad++; $display("FAIL basic_idle got wn=%b act=%b exp 1 0", write_n, active); end
  endtask

  task automatic test_busy_hold;
    int n;
    busy = 1'b1;
    open = 1'b1;
    wren = 1'b1;
    data = 16'h00FF;
    tick;
    data = 16'h0F01;
    tick;
    wren = 1'b0;
    n = 0;
    while (ce_n !== 1'b0 && n < 20) begin tick; n++; end
    total++;
    if (ce_n !== 1'b0) begin bad++; $display("FAIL busy_present got ce_n=%b exp 0 (timeout)", ce_n); end
    for (int k = 0; k < 3; k++) begin
      tick;
      total++;
      if (ce_n !== 1'b0 || icap_i !== 16'h00FF || words !== 32'd0) begin bad++; $display("FAIL busy_hold%0d got ce_n=%b i=%h w=%0d exp 0 00ff 0", k, ce_n, icap_i, words); end
    end
    busy = 1'b0;
    tick;
    total++;
    if (words !== 32'd1 || icap_i !== 16'hF080) begin bad++; $display("FAIL busy_release got w=%0d i=%h exp 1 f080", words, icap_i); end
    tick;
    total++;
    if (words !== 32'd2 || ce_n !== 1'b1) begin bad++; $display("FAIL busy_second got w=%0d ce_n=%b exp 2 1", words, ce_n); end
    open = 1'b0;
    n = 0;
    while (active !== 1'b0 && n < 20) begin tick; n++; end
  endtask

  task automatic test_overflow;
    int n;
    busy = 1'b1;
    open = 1'b1;
    wren = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      data = 16'(k);
      tick;
      // one word has moved into the output register, so the FIFO fills on write 17
      if (k == 16) begin
        total++;
        if (full !== 1'b0) begin bad++; $display("FAIL ovf_not_full got full=%b exp 0", full); end
      end
      if (k == 17) begin
        total++;
        if (full !== 1'b1 || overflow !== 1'b0) begin bad++; $display("FAIL ovf_full got full=%b ov=%b exp 1 0", full, overflow); end
      end
      if (k == 18) begin
        total++;
        if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got ov=%b exp 1", overflow); end
      end
    end
    wren = 1'b0;
    open = 1'b0;
    tick;
    open = 1'b1;
    tick;
    total++;
    if (overflow !== 1'b0 || words !== 32'd0) begin bad++; $display("FAIL ovf_clear got ov=%b w=%0d exp 0 0", overflow, words); end
    busy = 1'b0;
    repeat (25) tick;
    total++;
    if (words !== 32'd17 || full !== 1'b0 || ce_n !== 1'b1 || icap_i !== 16'h0088) begin bad++; $display("FAIL ovf_drain got w=%0d full=%b ce_n=%b i=%h exp 17 0 1 0088", words, full, ce_n, icap_i); end
    open = 1'b0;
    n = 0;
    while (active !== 1'b0 && n < 20) begin tick; n++; end
  endtask

  task automatic test_drain;
    int ce_rise, wn_rise, viol;
    logic pce, pwn;
    busy = 1'b0;
    open = 1'b1;
    wren = 1'b1;
    for (int k = 1; k <= 5; k++) begin data = 16'(k); tick; end
    wren = 1'b0;
    open = 1'b0;
    ce_rise = -1;
    wn_rise = -1;
    viol = 0;
    pce = ce_n;
    pwn = write_n;
    for (int t = 0; t < 30; t++) begin
      tick;
      if (write_n !== pwn && (ce_n === 1'b0 || pce === 1'b0)) viol++;
      if (ce_n === 1'b1 && pce === 1'b0) ce_rise = t;
      if (write_n === 1'b1 && pwn === 1'b0) wn_rise = t;
      pce = ce_n;
      pwn = write_n;
    end
    total++;
    if (words !== 32'd5 || icap_i !== 16'h00A0) begin bad++; $display("FAIL drain_words got w=%0d i=%h exp 5 00a0", words, icap_i); end
    total++;
    if (active !== 1'b0 || write_n !== 1'b1 || viol !== 0) begin bad++; $display("FAIL drain_idle got act=%b wn=%b viol=%0d exp 0 1 0", active, write_n, viol); end
    total++;
    if (ce_rise < 0 || wn_rise !== ce_rise + 1) begin bad++; $display("FAIL drain_hold got wn_rise=%0d ce_rise=%0d exp wn_rise=ce_rise+1", wn_rise, ce_rise); end
  endtask

  task automatic test_reset_mid;
    busy = 1'b0;
    open = 1'b1;
    wren = 1'b1;
    for (int k = 1; k <= 6; k++) begin data = 16'(k); tick; end
    wren = 1'b0;
    total++;
    if (ce_n !== 1'b0 || words !== 32'd2) begin bad++; $display("FAIL rstmid_pre got ce_n=%b w=%0d exp 0 2", ce_n, words); end
    rst = 1'b1;
    tick;
    total++;
    if ({ce_n, write_n, full, words, icap_i, active} !== {1'b1, 1'b1, 1'b0, 32'h0, 16'h0, 1'b0}) begin bad++; $display("FAIL rstmid_values got ce_n=%b wn=%b full=%b w=%0d i=%h act=%b", ce_n, write_n, full, words, icap_i, active); end
    rst = 1'b0;
    repeat (4) tick;
    total++;
    if (ce_n !== 1'b1 || active !== 1'b0 || full !== 1'b0) begin bad++; $display("FAIL rstmid_empty got ce_n=%b act=%b full=%b exp 1 0 0", ce_n, active, full); end
    open = 1'b0;
    tick;
  endtask

  task automatic test_no_swap_pushpop;
    int n;
    open0 = 1'b1;
    busy0 = 1'b1;
    wren0 = 1'b1;
    data0 = 16'h1234;
    tick;
    wren0 = 1'b0;
    n = 0;
    while (ce_n0 !== 1'b0 && n < 20) begin tick; n++; end
    total++;
    if (ce_n0 !== 1'b0 || icap_i0 !== 16'h1234) begin bad++; $display("FAIL noswap_word got ce_n=%b i=%h exp 0 1234", ce_n0, icap_i0); end
    wren0 = 1'b1;
    for (int k = 0; k < 8; k++) begin data0 = 16'(k); tick; end
    data0 = 16'h0055;
    busy0 = 1'b0;
    tick;
    busy0 = 1'b1;
    repeat (7) tick;
    total++;
    if (full0 !== 1'b0 || words0 !== 32'd1 || icap_i0 !== 16'h0000) begin bad++; $display("FAIL pushpop_count got full=%b w=%0d i=%h exp 0 1 0000", full0, words0, icap_i0); end
    tick;
    total++;
    if (full0 !== 1'b1 || overflow0 !== 1'b0) begin bad++; $display("FAIL pushpop_full got full=%b ov=%b exp 1 0", full0, overflow0); end
    wren0 = 1'b0;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_busy_hold;
    test_overflow;
    test_drain;
    test_reset_mid;
    test_no_swap_pushpop;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
